// File: rtl/muldiv_sequencer.sv
// Sequential signed multiply/divide unit for a MIPS-style Hi/Lo pipeline.
// A multiply runs as 32 shift-add steps and a divide runs as 32 restoring
// shift-subtract steps. Both work on operand magnitudes. The signs are
// applied on the last step, and the result is written into hi/lo on the
// edge that enters DONE.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_start,
  input  logic             div_start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic             hi_lo_write,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    MULT  = 3'd1,
    DIV   = 3'd2,
    DONE  = 3'd3,
    DZERO = 3'd4
  } state_t;

  state_t             state;
  logic [CW-1:0]      count;
  // Multiply: upper half is the running partial product and lower half is
  // the multiplier being shifted out.
  // Divide: upper half is the partial remainder and lower half is the
  // dividend shifted out while quotient bits are shifted in.
  logic [2*WIDTH-1:0] acc;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]   opnd;
  logic               sign_a;
  logic               sign_b;

  // Magnitudes of the live operands, captured when a start is accepted.
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;

  // One datapath step for each operation, plus the sign-corrected results.
  logic [WIDTH:0]     mult_sum;
  logic [WIDTH:0]     mult_addend;
  logic [2*WIDTH-1:0] mult_next;
  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [WIDTH-1:0]   quot_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // Operand magnitudes; the most negative value maps onto itself, which is
  // still the correct unsigned magnitude.
  always_comb begin
    mag_a = op_a[WIDTH-1] ? (~op_a + 1'b1) : op_a;
    mag_b = op_b[WIDTH-1] ? (~op_b + 1'b1) : op_b;
  end

  // Shift-add multiply step and restoring divide step, plus sign correction.
  always_comb begin
    // Multiply: add the multiplicand when the current multiplier bit is set,
    // then shift the whole 65-bit quantity right by one.
    mult_addend = acc[0] ? {1'b0, opnd} : '0;
    mult_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + mult_addend;
    mult_next   = {mult_sum, acc[WIDTH-1:1]};
    prod_fixed  = (sign_a ^ sign_b) ? (~mult_next + 1'b1) : mult_next;

    // Divide: shift the remainder left and pull in the next dividend bit.
    // Then try to subtract the divisor. The partial remainder is always below
    // the divisor, so bit WIDTH of the difference is set exactly when the
    // subtraction would go negative.
    div_shift = acc[2*WIDTH-1:WIDTH-1];
    div_diff  = div_shift - {1'b0, opnd};
    if (!div_diff[WIDTH]) begin
      div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    quot_fixed = (sign_a ^ sign_b) ? (~div_next[WIDTH-1:0] + 1'b1)
                                   : div_next[WIDTH-1:0];
    rem_fixed  = sign_a ? (~div_next[2*WIDTH-1:WIDTH] + 1'b1)
                        : div_next[2*WIDTH-1:WIDTH];
  end

  // Sequencer FSM with registered status outputs and Hi/Lo result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      acc         <= '0;
      opnd        <= '0;
      sign_a      <= 1'b0;
      sign_b      <= 1'b0;
      hi          <= '0;
      lo          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi_lo_write <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      done        <= 1'b0;
      hi_lo_write <= 1'b0;
      div_zero    <= 1'b0;
      case (state)
        IDLE: begin
          sign_a <= op_a[WIDTH-1];
          sign_b <= op_b[WIDTH-1];
          count  <= LAST_STEP;
          if (mult_start) begin
            // The multiply wins when both starts arrive together.
            acc   <= {{WIDTH{1'b0}}, mag_b};
            opnd  <= mag_a;
            state <= MULT;
            busy  <= 1'b1;
          end else if (div_start) begin
            acc  <= {{WIDTH{1'b0}}, mag_a};
            opnd <= mag_b;
            busy <= 1'b1;
            if (op_b == '0) begin
              state    <= DZERO;
              div_zero <= 1'b1;
            end else begin
              state <= DIV;
            end
          end
        end
        MULT: begin
          acc   <= mult_next;
          count <= count - 1'b1;
          if (count == '0) begin
            hi          <= prod_fixed[2*WIDTH-1:WIDTH];
            lo          <= prod_fixed[WIDTH-1:0];
            state       <= DONE;
            done        <= 1'b1;
            hi_lo_write <= 1'b1;
          end
        end
        DIV: begin
          acc   <= div_next;
          count <= count - 1'b1;
          if (count == '0) begin
            hi          <= rem_fixed;
            lo          <= quot_fixed;
            state       <= DONE;
            done        <= 1'b1;
            hi_lo_write <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        DZERO: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and random checks of muldiv_sequencer against a plain-arithmetic
// signed multiply/divide reference.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_start;
  logic        div_start;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic        hi_lo_write;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_zero;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] prev_hi;
  logic [31:0] prev_lo;

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .mult_start  (mult_start),
    .div_start   (div_start),
    .op_a        (op_a),
    .op_b        (op_b),
    .busy        (busy),
    .done        (done),
    .hi_lo_write (hi_lo_write),
    .hi          (hi),
    .lo          (lo),
    .div_zero    (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result as {hi, lo}: signed 64-bit product, or {remainder, quotient}.
  // SystemVerilog division truncates toward zero and the remainder takes the
  // dividend's sign, which matches MIPS div.
  function automatic logic [63:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint p;
    longint q;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (!is_div) begin
      p = sa * sb;
      return p;
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  function automatic logic [31:0] pick();
    logic [31:0] corners [6];
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'hFFFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'h7FFF_FFFF;
    corners[5] = 32'hFFFF_FFFE;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  // Run one full operation and check latency, pulses and the result.
  task automatic run_op(input string tag, input bit is_div, input logic [31:0] a,
                        input logic [31:0] b, input bit both, input bit glitch);
    logic [63:0] exp;
    int dones;
    dones = 0;
    exp = model(is_div && !both, a, b);
    @(negedge clk);
    op_a = a;
    op_b = b;
    mult_start = !is_div || both;
    div_start  = is_div || both;
    @(negedge clk);
    mult_start = 1'b0;
    div_start  = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    check({tag, "_busy_accept"}, 64'(busy), 64'd1);
    for (int k = 1; k <= 32; k++) begin
      div_start = glitch && (k == 10);
      @(negedge clk);
      if (done) dones++;
      if (k == 16) begin
        check({tag, "_hilo_stable"}, {hi, lo}, {prev_hi, prev_lo});
        check({tag, "_busy_mid"}, 64'(busy), 64'd1);
      end
    end
    div_start = 1'b0;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hlw"}, 64'(hi_lo_write), 64'd1);
    check({tag, "_result"}, {hi, lo}, exp);
    @(negedge clk);
    if (done) dones++;
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    check({tag, "_one_done"}, 64'(dones), 64'd1);
    $display("op %s div=%0d a=%h b=%h -> hi=%h lo=%h", tag, is_div && !both, a, b,
             exp[63:32], exp[31:0]);
    prev_hi = exp[63:32];
    prev_lo = exp[31:0];
  endtask

  initial begin
    reset = 1'b1;
    mult_start = 1'b0;
    div_start = 1'b0;
    op_a = '0;
    op_b = '0;
    prev_hi = '0;
    prev_lo = '0;
    #1;
    check("reset_outputs", {26'd0, busy, done, hi_lo_write, div_zero, hi, lo}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed examples.
    run_op("mul_7x-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_-7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op("mul_min2", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    run_op("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op("div_7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0);

    // Divide by zero: one-cycle div_zero, no done, Hi/Lo untouched.
    @(negedge clk);
    op_a = 32'h1234_5678;
    op_b = 32'd0;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    check("dz_flag", 64'(div_zero), 64'd1);
    check("dz_no_done", {62'd0, done, hi_lo_write}, 64'd0);
    check("dz_busy", 64'(busy), 64'd1);
    check("dz_hilo", {hi, lo}, {prev_hi, prev_lo});
    @(negedge clk);
    check("dz_after", {61'd0, div_zero, done, busy}, 64'd0);
    check("dz_hilo_after", {hi, lo}, {prev_hi, prev_lo});
    $display("op dzero a=12345678 b=00000000 -> div_zero pulse");

    // Both starts together: multiply wins. Then a stray div_start mid-operation.
    run_op("both", 1'b0, 32'hFFFF_FF00, 32'd300, 1'b1, 1'b0);
    run_op("glitch", 1'b0, 32'd123457, 32'hFFFE_0001, 1'b0, 1'b1);

    // Reset at cycle 15 of a divide aborts the operation.
    @(negedge clk);
    op_a = 32'd1000;
    op_b = 32'd7;
    div_start = 1'b1;
    @(negedge clk);
    div_start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_async", {26'd0, busy, done, hi_lo_write, div_zero, hi, lo}, 64'd0);
    prev_hi = '0;
    prev_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    begin
      int stray;
      stray = 0;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (done || hi_lo_write || busy) stray++;
      end
      check("rst_no_done", 64'(stray), 64'd0);
    end
    $display("op reset mid-divide -> aborted");
    run_op("post_rst", 1'b1, 32'd1000, 32'd7, 1'b0, 1'b0);

    // Random operations.
    for (int i = 0; i < 24; i++) begin
      bit is_div;
      logic [31:0] a;
      logic [31:0] b;
      is_div = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      if (is_div && b == 32'd0) b = 32'd3;
      run_op("rand", is_div, a, b, 1'b0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
